// File: rtl/sm4_encryptor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sm4_encryptor_pkg
// Purpose : Shared types for the SM4 encryptor and its CBC client.
// Revision: 1.0  initial release
// ============================================================================
package sm4_encryptor_pkg;

    localparam int group_size_p = 128;

    typedef logic [group_size_p-1:0] sm4_block_t;

    typedef enum logic [1:0] {
        eClientIdle,
        eClientRun,
        eClientDrain
    } sm4_client_state_e;

    // One outstanding request: value XORed into its result, plus end-of-message mark.
    typedef struct packed {
        sm4_block_t xor_val;
        logic       last;
    } sm4_chain_entry_s;

endpackage
`default_nettype wire

// File: rtl/sm4_chain_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sm4_chain_fifo
// Purpose : Synchronous FIFO of chain entries, one per outstanding request.
// Revision: 1.0  initial release
// ============================================================================
module sm4_chain_fifo
    import sm4_encryptor_pkg::*;
#(
    parameter int depth_p = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  sm4_chain_entry_s           data_i,
    input  logic                       pop_i,
    output sm4_chain_entry_s           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(depth_p):0]   count_o
);

    localparam int ptr_w_lp = $clog2(depth_p);

    sm4_chain_entry_s      r_mem [depth_p];
    logic [ptr_w_lp-1:0]   r_wr_ptr;
    logic [ptr_w_lp-1:0]   r_rd_ptr;
    logic [ptr_w_lp:0]     r_count;
    logic                  w_push;
    logic                  w_pop;

    // A pop at full does not free the slot until the following cycle.
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign full_o  = (r_count == (ptr_w_lp+1)'(depth_p));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{ptr_w_lp{1'b0}}, w_push} - {{ptr_w_lp{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/sm4_cbc_client.sv
`default_nettype none
// ============================================================================
// Module  : sm4_cbc_client
// Purpose : ECB/CBC initiator in front of one SM4 encryptor, pipelined requests.
// Revision: 1.0  initial release
// ============================================================================
module sm4_cbc_client
    import sm4_encryptor_pkg::*;
#(
    parameter int max_inflight_p = 4,
    parameter int count_width_p  = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [127:0]              key_i,
    input  logic [127:0]              iv_i,
    input  logic                      cbc_i,
    input  logic                      decode_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [count_width_p-1:0]  blocks_done_o,
    input  logic [127:0]              data_i,
    input  logic                      last_i,
    input  logic                      data_v_i,
    output logic                      data_ready_o,
    output logic [127:0]              content_o,
    output logic [127:0]              key_o,
    output logic                      encode_or_decode_o,
    output logic                      v_o,
    input  logic                      ready_i,
    input  logic [127:0]              crypt_i,
    input  logic                      v_i,
    output logic                      yumi_o,
    output logic                      invalid_cache_o,
    output logic [127:0]              data_o,
    output logic                      data_v_o,
    input  logic                      data_yumi_i
);

    sm4_client_state_e                 r_state;
    sm4_client_state_e                 w_state_next;
    sm4_block_t                        r_key;
    sm4_block_t                        r_chain;
    sm4_block_t                        r_data;
    logic                              r_key_seen;
    logic                              r_cbc;
    logic                              r_decode;
    logic                              r_data_v;
    logic [count_width_p-1:0]          r_blocks_done;
    logic                              w_idle;
    logic                              w_start;
    logic                              w_serial;
    logic                              w_cbc_dec;
    logic                              w_fire;
    logic                              w_fifo_full;
    logic                              w_fifo_empty;
    logic [$clog2(max_inflight_p):0]   w_inflight;
    sm4_chain_entry_s                  w_push_entry;
    sm4_chain_entry_s                  w_head;

    assign w_idle    = (r_state == eClientIdle);
    assign w_start   = reset_i & start_i & w_idle;
    assign w_serial  = r_cbc & ~r_decode;
    assign w_cbc_dec = r_cbc & r_decode;

    // CBC encode needs the previous ciphertext, so only one request may be in flight.
    assign v_o          = (r_state == eClientRun) & data_v_i & ~w_fifo_full
                          & ~(w_serial & (w_inflight != '0));
    assign w_fire       = v_o & ready_i;
    assign data_ready_o = w_fire;
    assign content_o    = w_serial ? (data_i ^ r_chain) : data_i;

    assign w_push_entry.xor_val = w_cbc_dec ? r_chain : '0;
    assign w_push_entry.last    = last_i;

    assign yumi_o = ~w_idle & v_i & ~w_fifo_empty & (~r_data_v | data_yumi_i);

    assign invalid_cache_o    = w_start & (~r_key_seen | (key_i != r_key));
    assign key_o              = r_key;
    assign encode_or_decode_o = r_decode;
    assign busy_o             = ~w_idle;
    assign data_o             = r_data;
    assign data_v_o           = r_data_v;
    assign blocks_done_o      = r_blocks_done;

    sm4_chain_fifo #(
        .depth_p (max_inflight_p)
    ) u_chain_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_fire),
        .data_i  (w_push_entry),
        .pop_i   (yumi_o),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_inflight)
    );

    always_comb begin
        w_state_next = r_state;
        done_o       = 1'b0;
        unique case (r_state)
            eClientIdle:  if (w_start) w_state_next = eClientRun;
            eClientRun:   if (w_fire & last_i) w_state_next = eClientDrain;
            eClientDrain: begin
                if (w_fifo_empty & ~r_data_v) begin
                    w_state_next = eClientIdle;
                    done_o       = 1'b1;
                end
            end
            default:      w_state_next = eClientIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state       <= eClientIdle;
            r_key         <= '0;
            r_key_seen    <= 1'b0;
            r_cbc         <= 1'b0;
            r_decode      <= 1'b0;
            r_chain       <= '0;
            r_data        <= '0;
            r_data_v      <= 1'b0;
            r_blocks_done <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_key      <= key_i;
                r_key_seen <= 1'b1;
                r_cbc      <= cbc_i;
                r_decode   <= decode_i;
                r_chain    <= iv_i;
            end else if (w_fire & w_cbc_dec) begin
                r_chain <= data_i;
            end else if (yumi_o & w_serial) begin
                r_chain <= crypt_i;
            end
            // A new result may replace the one being taken downstream in the same cycle.
            if (yumi_o) begin
                r_data   <= crypt_i ^ w_head.xor_val;
                r_data_v <= 1'b1;
            end else if (data_yumi_i) begin
                r_data_v <= 1'b0;
            end
            if (w_start) begin
                r_blocks_done <= '0;
            end else if (data_yumi_i & r_data_v) begin
                r_blocks_done <= r_blocks_done + count_width_p'(1);
            end
        end
    end

endmodule
`default_nettype wire
